vid2is_format_sequencer: RTL

- Single-clock controller that sits between the Vid2IS resolution detector and the Avalon-ST output stage.
- Watches the detector's stability, validity and resolution-change signals, and qualifies a new format over a programmable number of fields.
- Issues one control-packet request per format (req/ack handshake) with latched width/height/interlace values.
- Gates the video output so it only opens and closes on field boundaries.

---
 rtl/vid2is_format_sequencer_if.sv | 40 ++++
 rtl/vid2is_format_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vid2is_format_sequencer_if.sv
// Control/status bundle between the Vid2IS resolution detector, the format
// sequencer and the Avalon-ST output stage.
interface vid2is_format_sequencer_if #(
  parameter int CHANGE_CNT_WIDTH = 8
);
  logic                        go;
  logic                        start_new_field;
  logic                        f;
  logic                        stable;
  logic                        resolution_valid;
  logic                        resolution_change;
  logic                        interlaced;
  logic [14:0]                 active_sample_count;
  logic [13:0]                 active_line_count_f0;
  logic [13:0]                 active_line_count_f1;
  logic                        ctrl_pkt_ack;
  logic                        ctrl_pkt_req;
  logic [13:0]                 ctrl_width;
  logic [13:0]                 ctrl_height;
  logic [3:0]                  ctrl_interlace;
  logic                        video_enable;
  logic [2:0]                  status;
  logic [CHANGE_CNT_WIDTH-1:0] change_count;

  modport master (
    output go, start_new_field, f, stable, resolution_valid, resolution_change,
           interlaced, active_sample_count, active_line_count_f0,
           active_line_count_f1, ctrl_pkt_ack,
    input  ctrl_pkt_req, ctrl_width, ctrl_height, ctrl_interlace,
           video_enable, status, change_count
  );

  modport slave (
    input  go, start_new_field, f, stable, resolution_valid, resolution_change,
           interlaced, active_sample_count, active_line_count_f0,
           active_line_count_f1, ctrl_pkt_ack,
    output ctrl_pkt_req, ctrl_width, ctrl_height, ctrl_interlace,
           video_enable, status, change_count
  );
endinterface

// File: rtl/vid2is_format_sequencer.sv
// Qualifies a detected video format over several fields, issues one control
// packet per format and gates the pixel stream on field boundaries.
module vid2is_format_sequencer #(
  parameter int CONFIRM_FIELDS   = 2,
  parameter int CHANGE_CNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  vid2is_format_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_WAIT_STABLE = 3'd1;
  localparam logic [2:0] ST_SEND_CTRL   = 3'd2;
  localparam logic [2:0] ST_STREAM      = 3'd3;
  localparam logic [2:0] ST_DRAIN       = 3'd4;

  localparam logic [3:0] CONFIRM_LIMIT = 4'(CONFIRM_FIELDS);

  logic [2:0]                  state;
  logic [3:0]                  field_cnt;
  logic [3:0]                  field_cnt_inc;
  logic                        res_chg_p1;
  logic                        chg_edge;
  logic                        qualified;
  logic                        disturb;
  logic                        acked;
  logic                        stale;
  logic                        req;
  logic                        ven;
  logic [13:0]                 width_q;
  logic [13:0]                 height_q;
  logic [3:0]                  interlace_q;
  logic [CHANGE_CNT_WIDTH-1:0] chg_cnt;
  logic                        unused_valid_bits;

  function automatic logic [13:0] calc_height(input logic       il,
                                               input logic [12:0] l0,
                                               input logic [12:0] l1);
    calc_height = il ? ({1'b0, l0} + {1'b0, l1}) : {1'b0, l0};
  endfunction

  function automatic logic [3:0] calc_interlace(input logic il, input logic fld);
    if (!il)
      calc_interlace = 4'b0011;
    else if (fld)
      calc_interlace = 4'b1100;
    else
      calc_interlace = 4'b1000;
  endfunction

  assign chg_edge      = bus.resolution_change ^ res_chg_p1;
  assign qualified     = bus.stable & bus.resolution_valid & bus.go;
  assign disturb       = chg_edge | ~qualified;
  assign field_cnt_inc = field_cnt + 4'd1;

  // Detector valid bits are implied by resolution_valid; they are not used here.
  assign unused_valid_bits = ^{bus.active_sample_count[0],
                               bus.active_line_count_f0[0],
                               bus.active_line_count_f1[0]};

  // Change-edge detection and wrap-around event counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_chg_p1 <= 1'b0;
      chg_cnt    <= '0;
    end else begin
      res_chg_p1 <= bus.resolution_change;
      if (chg_edge)
        chg_cnt <= chg_cnt + 1'b1;
    end
  end

  // Format qualification / handshake / stream gating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      field_cnt   <= 4'd0;
      acked       <= 1'b0;
      stale       <= 1'b0;
      req         <= 1'b0;
      ven         <= 1'b0;
      width_q     <= 14'd0;
      height_q    <= 14'd0;
      interlace_q <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.go) begin
            state     <= ST_WAIT_STABLE;
            field_cnt <= 4'd0;
          end
        end

        ST_WAIT_STABLE: begin
          if (!bus.go) begin
            state     <= ST_IDLE;
            field_cnt <= 4'd0;
          end else if (disturb) begin
            field_cnt <= 4'd0;
          end else if (bus.start_new_field) begin
            if (field_cnt_inc == CONFIRM_LIMIT) begin
              state       <= ST_SEND_CTRL;
              field_cnt   <= 4'd0;
              req         <= 1'b1;
              stale       <= 1'b0;
              acked       <= 1'b0;
              width_q     <= bus.active_sample_count[14:1];
              height_q    <= calc_height(bus.interlaced,
                                         bus.active_line_count_f0[13:1],
                                         bus.active_line_count_f1[13:1]);
              interlace_q <= calc_interlace(bus.interlaced, bus.f);
            end else begin
              field_cnt <= field_cnt_inc;
            end
          end
        end

        ST_SEND_CTRL: begin
          if (!acked) begin
            // The handshake always completes; disturbances only mark the format stale.
            if (disturb)
              stale <= 1'b1;
            if (req && bus.ctrl_pkt_ack) begin
              req <= 1'b0;
              if (stale || disturb) begin
                state     <= ST_WAIT_STABLE;
                field_cnt <= 4'd0;
              end else begin
                acked <= 1'b1;
              end
            end
          end else if (disturb) begin
            state     <= ST_WAIT_STABLE;
            field_cnt <= 4'd0;
            acked     <= 1'b0;
          end else if (bus.start_new_field) begin
            state <= ST_STREAM;
            ven   <= 1'b1;
            acked <= 1'b0;
          end
        end

        ST_STREAM: begin
          if (disturb)
            state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // Close the gate only on a field boundary.
          if (bus.start_new_field) begin
            ven       <= 1'b0;
            field_cnt <= 4'd0;
            state     <= bus.go ? ST_WAIT_STABLE : ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
          ven   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ctrl_pkt_req   = req;
  assign bus.ctrl_width     = width_q;
  assign bus.ctrl_height    = height_q;
  assign bus.ctrl_interlace = interlace_q;
  assign bus.video_enable   = ven;
  assign bus.status         = state;
  assign bus.change_count   = chg_cnt;

endmodule
